// File: rtl/fifo_pkg.sv
// Shared definitions for the fifo_sync read-side controller.
package fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_e;

  // Words owed to the output buffer: those already held plus any read in flight.
  function automatic logic [1:0] occupancy(input logic [1:0] cnt, input logic inflight);
    return cnt + {1'b0, inflight};
  endfunction

endpackage

// File: rtl/fifo_sync_reader_if.sv
// FIFO-side and stream-side signals of the reader, with the reader as master.
// Handshake: a word transfers in any cycle where m_valid_o and m_ready_i are both high;
// once m_valid_o is high, m_data_o/m_last_o hold until that transfer happens.
interface fifo_sync_reader_if
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);
  logic [DATA_WIDTH-1:0] fifo_data_i;
  logic                  fifo_empty_i;
  logic                  fifo_r_en_o;
  logic [DATA_WIDTH-1:0] m_data_o;
  logic                  m_valid_o;
  logic                  m_ready_i;
  logic                  m_last_o;

  modport master (
    input  fifo_data_i, fifo_empty_i, m_ready_i,
    output fifo_r_en_o, m_data_o, m_valid_o, m_last_o
  );

  modport slave (
    output fifo_data_i, fifo_empty_i, m_ready_i,
    input  fifo_r_en_o, m_data_o, m_valid_o, m_last_o
  );
endinterface

// File: rtl/fifo_reader_buf.sv
// Two-entry in-order skid buffer; the head register drives the output word directly.
module fifo_reader_buf
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  resetn_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] head_o,
  output logic [1:0]            cnt_o
);

  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;
  logic [1:0]            cnt_q, cnt_d;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    unique case (cnt_q)
      2'd0: begin
        if (push_i) begin
          head_d = push_data_i;
          cnt_d  = 2'd1;
        end
      end
      2'd1: begin
        if (push_i && pop_i) begin
          head_d = push_data_i;
        end else if (push_i) begin
          tail_d = push_data_i;
          cnt_d  = 2'd2;
        end else if (pop_i) begin
          cnt_d = 2'd0;
        end
      end
      default: begin
        // Full: a push can only arrive together with a pop, so the tail shifts up.
        if (pop_i) begin
          head_d = tail_q;
          if (push_i) begin
            tail_d = push_data_i;
          end else begin
            cnt_d = 2'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  assign head_o = head_q;
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/fifo_sync_reader.sv
// Read-side controller for fifo_sync: issues reads, hides the one-cycle read latency
// and presents a valid/ready stream with a per-burst last marker.
module fifo_sync_reader
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int BURST_LEN  = 4,
  parameter int CNT_BITS   = 16
) (
  input  logic                clk_i,
  input  logic                resetn_i,
  input  logic                enable_i,
  fifo_sync_reader_if.master  bus,
  output logic                busy_o,
  output logic [CNT_BITS-1:0] rd_count_o,
  output state_e              dbg_state_o
);

  localparam int                BEAT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);

  state_e              state_q, state_d;
  logic                inflight_q;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [CNT_BITS-1:0] rd_count_q, rd_count_d;

  logic [1:0]            buf_cnt;
  logic [1:0]            occ;
  logic [DATA_WIDTH-1:0] head;
  logic                  m_valid;
  logic                  pop;
  logic                  issue;

  fifo_reader_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf (
    .clk_i       (clk_i),
    .resetn_i    (resetn_i),
    .push_i      (inflight_q),
    .push_data_i (bus.fifo_data_i),
    .pop_i       (pop),
    .head_o      (head),
    .cnt_o       (buf_cnt)
  );

  assign m_valid = (buf_cnt != 2'd0);
  assign pop     = m_valid && bus.m_ready_i;
  assign occ     = occupancy(buf_cnt, inflight_q);

  // A full buffer may still accept a new read when a word leaves this same cycle.
  assign issue = (state_q == ST_RUN) && !bus.fifo_empty_i &&
                 ((occ < 2'd2) || ((occ == 2'd2) && pop));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (enable_i) state_d = ST_RUN;
      ST_RUN:  if (!enable_i) state_d = ST_STOP;
      ST_STOP: begin
        if (enable_i) begin
          state_d = ST_RUN;
        end else if (!inflight_q && (buf_cnt == 2'd0)) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    beat_d     = beat_q;
    rd_count_d = rd_count_q;
    if (pop) begin
      beat_d     = (beat_q == BEAT_LAST) ? '0 : beat_q + BEAT_W'(1);
      rd_count_d = rd_count_q + CNT_BITS'(1);
    end
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q    <= ST_IDLE;
      inflight_q <= 1'b0;
      beat_q     <= '0;
      rd_count_q <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= issue;
      beat_q     <= beat_d;
      rd_count_q <= rd_count_d;
    end
  end

  assign bus.fifo_r_en_o = issue;
  assign bus.m_data_o    = head;
  assign bus.m_valid_o   = m_valid;
  assign bus.m_last_o    = m_valid && (beat_q == BEAT_LAST);

  assign busy_o      = (state_q != ST_IDLE) || inflight_q || (buf_cnt != 2'd0);
  assign rd_count_o  = rd_count_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fifo_sync_reader.sv
// Bench for fifo_sync_reader: behavioural fifo_sync model, in-order scoreboard, stream monitor.
module tb_fifo_sync_reader;
  import fifo_pkg::*;

  localparam int DW  = 8;
  localparam int BL  = 4;
  localparam int CB  = 16;
  localparam int CB4 = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  logic enable;
  always #5 clk = ~clk;

  logic           busy, busy4;
  logic [CB-1:0]  rd_count;
  logic [CB4-1:0] rd_count4;
  state_e         dbg_state, dbg_state4;

  fifo_sync_reader_if #(.DATA_WIDTH(DW)) bus ();
  fifo_sync_reader_if #(.DATA_WIDTH(DW)) bus4 ();

  fifo_sync_reader #(.DATA_WIDTH(DW), .BURST_LEN(BL), .CNT_BITS(CB)) dut (
    .clk_i       (clk),
    .resetn_i    (rst_n),
    .enable_i    (enable),
    .bus         (bus),
    .busy_o      (busy),
    .rd_count_o  (rd_count),
    .dbg_state_o (dbg_state)
  );

  // Narrow-counter copy fed with identical inputs, used for the wrap check.
  fifo_sync_reader #(.DATA_WIDTH(DW), .BURST_LEN(BL), .CNT_BITS(CB4)) dut4 (
    .clk_i       (clk),
    .resetn_i    (rst_n),
    .enable_i    (enable),
    .bus         (bus4),
    .busy_o      (busy4),
    .rd_count_o  (rd_count4),
    .dbg_state_o (dbg_state4)
  );

  assign bus4.fifo_data_i  = bus.fifo_data_i;
  assign bus4.fifo_empty_i = bus.fifo_empty_i;
  assign bus4.m_ready_i    = bus.m_ready_i;

  // ---------------- fifo_sync model ----------------
  logic [DW-1:0] fq[$];
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          rd_pending = 1'b0;

  always @(negedge clk) rd_pending = bus.fifo_r_en_o && !bus.fifo_empty_i;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fq.delete();
      bus.fifo_data_i  <= '0;
      bus.fifo_empty_i <= 1'b1;
    end else begin
      if (rd_pending && (fq.size() > 0)) bus.fifo_data_i <= fq.pop_front();
      if (wr_en) fq.push_back(wr_data);
      bus.fifo_empty_i <= (fq.size() == 0);
    end
  end

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  int     n_cmp = 0;
  int     n_err = 0;
  longint tot = 0;
  int     cyc = 0;
  int     pop_cyc_q[$];
  logic   stall_prev = 1'b0;
  logic [DW-1:0] stall_data;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      tot = 0;
      stall_prev = 1'b0;
    end else begin
      check("r_en_while_empty", {63'd0, bus.fifo_r_en_o && bus.fifo_empty_i}, 64'd0);
      check("rd_count", 64'(rd_count), 64'(tot[CB-1:0]));
      check("rd_count4", 64'(rd_count4), 64'(tot[CB4-1:0]));
      if (bus.m_valid_o) check("m_last", 64'(bus.m_last_o), 64'((tot % BL) == BL - 1));
      else               check("m_last_idle", 64'(bus.m_last_o), 64'd0);
      if (stall_prev) begin
        check("stall_valid", 64'(bus.m_valid_o), 64'd1);
        check("stall_data", 64'(bus.m_data_o), 64'(stall_data));
      end
      if (bus.m_valid_o && bus.m_ready_i) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", 64'(bus.m_data_o), 64'hDEAD_0000);
        end else begin
          check("m_data", 64'(bus.m_data_o), 64'(exp_q.pop_front()));
        end
        tot++;
        pop_cyc_q.push_back(cyc);
      end
      stall_prev = bus.m_valid_o && !bus.m_ready_i;
      stall_data = bus.m_data_o;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [DW-1:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    exp_q.push_back(d);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_exp_empty(input string name, input int budget);
    int done;
    done = 0;
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0) begin
        done = 1;
        break;
      end
      tick();
    end
    check(name, 64'(done), 64'd1);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int done;
    done = 0;
    for (int i = 0; i < budget; i++) begin
      if (!busy) begin
        done = 1;
        break;
      end
      tick();
    end
    check(name, 64'(done), 64'd1);
    check({name, "_state"}, 64'(dbg_state), 64'(ST_IDLE));
  endtask

  task automatic wait_issue(input string name, input int budget);
    int done;
    done = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.fifo_r_en_o && !bus.fifo_empty_i) begin
        done = 1;
        break;
      end
    end
    check(name, 64'(done), 64'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    longint tot0;
    rst_n          = 1'b0;
    enable         = 1'b0;
    wr_en          = 1'b0;
    wr_data        = '0;
    bus.m_ready_i  = 1'b0;
    repeat (3) tick();
    check("rst_r_en", 64'(bus.fifo_r_en_o), 64'd0);
    check("rst_valid", 64'(bus.m_valid_o), 64'd0);
    check("rst_last", 64'(bus.m_last_o), 64'd0);
    check("rst_data", 64'(bus.m_data_o), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_count", 64'(rd_count), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    rst_n = 1'b1;
    tick();

    // Full-rate burst of 0x00..0x0F.
    for (int i = 0; i < 16; i++) write_word(DW'(i));
    pop_cyc_q.delete();
    bus.m_ready_i = 1'b1;
    enable = 1'b1;
    wait_exp_empty("t1_drain", 100);
    tick();
    check("t1_pops", 64'(pop_cyc_q.size()), 64'd16);
    if (pop_cyc_q.size() == 16) check("t1_back_to_back", 64'(pop_cyc_q[15] - pop_cyc_q[0]), 64'd15);
    check("t1_rd_count", 64'(rd_count), 64'd16);
    enable = 1'b0;
    wait_idle("t1_idle", 20);

    // Alternating ready with random words.
    for (int i = 0; i < 16; i++) write_word(DW'($urandom_range(0, 255)));
    enable = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0) break;
      bus.m_ready_i = ~bus.m_ready_i;
      tick();
    end
    wait_exp_empty("t2_drain", 1);
    bus.m_ready_i = 1'b1;
    enable = 1'b0;
    wait_idle("t2_idle", 20);

    // Drop enable one cycle after the first read.
    for (int i = 0; i < 16; i++) write_word(DW'($urandom_range(0, 255)));
    tot0 = tot;
    enable = 1'b1;
    wait_issue("t3_first_read", 10);
    @(posedge clk);
    #1;
    enable = 1'b0;
    wait_idle("t3_idle", 20);
    check("t3_delivered", 64'(tot - tot0), 64'd2);
    check("t3_fifo_left", 64'(fq.size()), 64'd14);
    enable = 1'b1;
    wait_exp_empty("t3_resume_drain", 100);
    enable = 1'b0;
    wait_idle("t3_idle2", 20);

    // Empty FIFO: no reads, then a single write and its latency.
    enable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("t4_no_r_en", 64'(bus.fifo_r_en_o), 64'd0);
      check("t4_no_valid", 64'(bus.m_valid_o), 64'd0);
    end
    write_word(DW'($urandom_range(0, 255)));
    wait_issue("t4_read", 10);
    @(negedge clk);
    check("t4_valid_t1", 64'(bus.m_valid_o), 64'd0);
    @(negedge clk);
    check("t4_valid_t2", 64'(bus.m_valid_o), 64'd1);
    tick();
    wait_exp_empty("t4_drain", 20);
    enable = 1'b0;
    wait_idle("t4_idle", 20);

    // Random enable, ready and writes.
    for (int i = 0; i < 600; i++) begin
      enable        = ($urandom_range(0, 9) != 0);
      bus.m_ready_i = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) begin
        wr_en   = 1'b1;
        wr_data = DW'($urandom_range(0, 255));
        exp_q.push_back(wr_data);
      end else begin
        wr_en = 1'b0;
      end
      tick();
    end
    wr_en = 1'b0;
    enable = 1'b1;
    bus.m_ready_i = 1'b1;
    wait_exp_empty("t5_drain", 2000);
    enable = 1'b0;
    wait_idle("t5_idle", 20);

    // Asynchronous reset with a full output buffer.
    for (int i = 0; i < 8; i++) write_word(DW'($urandom_range(0, 255)));
    bus.m_ready_i = 1'b0;
    enable = 1'b1;
    repeat (8) tick();
    #3;
    rst_n = 1'b0;
    #1;
    check("ar_r_en", 64'(bus.fifo_r_en_o), 64'd0);
    check("ar_valid", 64'(bus.m_valid_o), 64'd0);
    check("ar_last", 64'(bus.m_last_o), 64'd0);
    check("ar_data", 64'(bus.m_data_o), 64'd0);
    check("ar_busy", 64'(busy), 64'd0);
    check("ar_count", 64'(rd_count), 64'd0);
    check("ar_count4", 64'(rd_count4), 64'd0);
    exp_q.delete();
    enable = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 20; i++) write_word(DW'($urandom_range(0, 255)));
    bus.m_ready_i = 1'b1;
    enable = 1'b1;
    wait_exp_empty("t6_drain", 100);
    tick();
    check("t6_rd_count", 64'(rd_count), 64'd20);
    check("t6_rd_count4_wrap", 64'(rd_count4), 64'd4);
    enable = 1'b0;
    wait_idle("t6_idle", 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fifo_sync_reader.md
# fifo_sync_reader

Read-side controller for `fifo_sync`. It drives the FIFO's `r_en` from `fifo_empty`, absorbs the FIFO's one-cycle read latency in a 2-entry output buffer, and presents the words as a valid/ready stream with a per-burst `last` marker. It sits between `fifo_sync` and any downstream consumer. With `m_ready_i` held high it sustains one word per clock.

## Interface
- `DATA_WIDTH`, 8: FIFO word width.
- `BURST_LEN`, 4: words per burst; `m_last_o` marks the final word of each burst; must be ≥1.
- `CNT_BITS`, 16: width of the delivered-word counter.

- `clk_i`  in  1  clock; all state on rising edge.
- `resetn_i`  in  1  reset, asynchronous, active-low.
- `enable_i`  in  1  allows new FIFO reads while high.
- `fifo_data_i`  in  DATA_WIDTH  `fifo_sync.data_out`.
- `fifo_empty_i`  in  1  `fifo_sync.fifo_empty`.
- `fifo_r_en_o`  out  1  `fifo_sync.r_en`.
- `m_data_o`  out  DATA_WIDTH  output word.
- `m_valid_o`  out  1  `m_data_o` valid.
- `m_ready_i`  in  1  consumer accepts the word.
- `m_last_o`  out  1  word is the last of a burst; qualified by `m_valid_o`.
- `busy_o`  out  1  state ≠ IDLE, or a read is in flight, or the buffer is non-empty.
- `rd_count_o`  out  CNT_BITS  delivered words; wraps modulo 2^CNT_BITS.

## Operation
- FIFO read contract: a read is issued in cycle t when `fifo_r_en_o`=1 and `fifo_empty_i`=0. Its word is on `fifo_data_i` in cycle t+1 and is captured at the end of t+1.
- `inflight`: 1-bit register. It is set when a read is issued and cleared when the word lands.
- `buf_cnt`: occupancy of the output buffer, 0..2. The buffer is 2-entry FIFO-ordered; the head drives `m_data_o`.
- Pop: `m_valid_o` and `m_ready_i` both high.
- Issue rule: `fifo_r_en_o` = state==RUN and !`fifo_empty_i` and (`buf_cnt`+`inflight` < 2, or (`buf_cnt`+`inflight` == 2 and pop)).
  - `fifo_r_en_o` is never asserted while `fifo_empty_i`=1.
  - The buffer can never overflow.
- State machine:
  - IDLE: leaves to RUN when `enable_i`=1.
  - RUN: leaves to STOP when `enable_i`=0.
  - STOP: issues no reads. Returns to RUN if `enable_i` rises again. Goes to IDLE when `inflight`=0 and `buf_cnt`=0.
- Words already in flight or buffered are always delivered, including in STOP.
- Burst counter `beat`, 0..BURST_LEN-1:
  - increments on each pop and wraps to 0 after BURST_LEN-1;
  - `m_last_o` = `m_valid_o` and `beat`==BURST_LEN-1;
  - does not reset on STOP or IDLE, so bursts span enable gaps.
- `rd_count_o` increments by 1 on each pop and wraps.
- Simultaneous events:
  - A landing word and a pop in the same cycle leave `buf_cnt` unchanged.
  - A word landing into an empty buffer is presented the next cycle, never combinationally.
- `m_data_o` must hold stable while `m_valid_o`=1 and `m_ready_i`=0.
- Reset mid-operation: all state clears immediately. An in-flight word is discarded, and `fifo_sync` must be reset together with this block.

## Timing
- Reset values: `fifo_r_en_o`=0, `m_valid_o`=0, `m_last_o`=0, `m_data_o`=0, `busy_o`=0, `rd_count_o`=0, state IDLE, `beat`=0, `buf_cnt`=0, `inflight`=0.
- Latency:
  - `enable_i` rising in cycle e gives state RUN in e+1, and `fifo_r_en_o` can first assert in e+1.
  - A read issued in cycle t gives `m_valid_o`=1 in cycle t+2.
- Throughput: 1 word/cycle while the FIFO is non-empty and `m_ready_i`=1.
- `fifo_r_en_o` is combinational from `fifo_empty_i`, `m_ready_i` and registered state. All other outputs are registered, except `m_last_o`, which is decoded from registers.

## Structure
- Shared package `fifo_pkg`: state encoding IDLE/RUN/STOP and the default `DATA_WIDTH`.
- Sub-module `fifo_reader_buf`: 2-entry buffer with push, pop, `cnt`, `head`.
- Top level: issue logic, state machine, `beat` and `rd_count_o`.

## Test plan
- Reset, then FIFO pre-filled with 16 words 0x00..0x0F, `enable_i`=1 and `m_ready_i`=1 → words 0x00..0x0F delivered on consecutive cycles in order; `m_last_o` on 0x03, 0x07, 0x0B, 0x0F; `rd_count_o`=16; `fifo_r_en_o` never high while empty.
- Same fill with `m_ready_i` toggling 1,0,1,0 → in-order delivery with no loss or duplicate; `m_data_o` stable during stalls; `buf_cnt` ≤ 2.
- `enable_i` dropped one cycle after the first read → exactly the in-flight and buffered words are delivered, then IDLE and `busy_o`=0; FIFO still holds the rest.
- FIFO empty, `enable_i`=1 → `fifo_r_en_o`=0 and `m_valid_o`=0 indefinitely. A single write then gives `m_valid_o` 2 cycles after `fifo_r_en_o`.
- Assert `resetn_i`=0 mid-stream with `buf_cnt`=2 → all outputs return to their reset values asynchronously; after reset release, `rd_count_o` restarts from 0.
- `CNT_BITS`=4 with 20 words delivered → `rd_count_o` wraps and reads 4.
